// File: rtl/key_flip.sv
// ----------------------------------------------------------------------------
// key_flip
//   Push-button to LED toggle. A raw, asynchronous, possibly bouncing key
//   level is passed through a two-flop synchroniser and a debounce counter.
//   Each debounced transition to the pressed level inverts led_out.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing synchronised samples needed
//                     before a key level change is accepted (>= 1)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   KEY_ACTIVE_LOW  : 0 -> key_in=1 is pressed, 1 -> key_in=0 is pressed
//   LED_INIT        : led_out value loaded during reset
//
// Ports
//   clk     : system clock, rising-edge active
//   rstn    : synchronous reset, active HIGH (legacy name, 1 = reset)
//   key_in  : raw button level, asynchronous to clk
//   led_out : registered LED drive, toggles once per accepted press
// ----------------------------------------------------------------------------
module key_flip #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16,
    parameter bit          KEY_ACTIVE_LOW  = 1'b0,
    parameter bit          LED_INIT        = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_in,
    output logic led_out
);

    // Key level that means "not pressed".
    localparam logic RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             key_db;
    logic [CNT_W-1:0] cnt;

    logic differ;
    logic commit;
    logic press;

    // A commit needs DEBOUNCE_CYCLES consecutive samples that differ from
    // the accepted level; the counter restarts whenever s2 returns to it.
    always_comb begin
        differ = (s2 != key_db);
        commit = differ && (cnt == CNT_LAST);
        press  = commit && (s2 != RELEASED);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            s1      <= RELEASED;
            s2      <= RELEASED;
            key_db  <= RELEASED;
            cnt     <= '0;
            led_out <= LED_INIT;
        end else begin
            s1 <= key_in;
            s2 <= s1;

            if (!differ) begin
                cnt <= '0;
            end else if (commit) begin
                key_db <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (press) begin
                led_out <= ~led_out;
            end
        end
    end

endmodule

// File: tb/tb_key_flip.sv
module tb_key_flip;

    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic key_in = 1'b0;
    logic led_out;

    int checks = 0;
    int failures = 0;

    key_flip #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16),
        .KEY_ACTIVE_LOW(1'b0),
        .LED_INIT(1'b0)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .key_in(key_in),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    // Behavioural reference: key samples reach the debouncer two edges after
    // they are taken; the accepted level flips when the last D samples seen
    // by the debouncer all disagree with it. A flip to 1 toggles the LED.
    bit pipe[2];
    bit win[$];
    bit m_db;
    bit m_led;

    task automatic model_edge(input bit r, input bit k);
        bit s2v;
        bit all_diff;
        if (r) begin
            pipe[0] = 1'b0;
            pipe[1] = 1'b0;
            win.delete();
            m_db  = 1'b0;
            m_led = 1'b0;
        end else begin
            s2v = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = k;
            win.push_back(s2v);
            if (win.size() > D) void'(win.pop_front());
            if (win.size() == D) begin
                all_diff = 1'b1;
                foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
                if (all_diff) begin
                    m_db = ~m_db;
                    if (m_db) m_led = ~m_led;
                end
            end
        end
    endtask

    // Drive one clock: inputs set mid-cycle, sampled at posedge, checked #1 later.
    task automatic step(input bit r, input bit k);
        rstn   = r;
        key_in = k;
        @(posedge clk);
        model_edge(r, k);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            checks++;
            if (led_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_led cycle=%0d got=%b exp=0", i, led_out);
            end
            checks++;
            if (dut.cnt !== 16'd0) begin
                failures++;
                $display("FAIL reset_cnt cycle=%0d got=%0d exp=0", i, dut.cnt);
            end
        end
    endtask

    task automatic test_clean_press();
        bit base;
        bit exp;
        settle();
        base = m_led;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            exp = base ^ (i >= 5);
            checks++;
            if (led_out !== exp) begin
                failures++;
                $display("FAIL clean_press edge=k+%0d got=%b exp=%b", i, led_out, exp);
            end
        end
    endtask

    task automatic test_glitch();
        bit base;
        settle();
        base = m_led;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i < 3) ? 1'b1 : 1'b0);
            checks++;
            if (led_out !== base || dut.key_db !== 1'b0) begin
                failures++;
                $display("FAIL glitch cycle=%0d led=%b exp=%b key_db=%b exp=0",
                         i, led_out, base, dut.key_db);
            end
        end
    endtask

    task automatic test_press_release_press();
        bit prev;
        int toggles = 0;
        bit base;
        settle();
        base = m_led;
        prev = led_out;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, (i < 10 || (i >= 20 && i < 30)) ? 1'b1 : 1'b0);
            if (led_out !== prev) toggles++;
            prev = led_out;
            checks++;
            if (led_out !== m_led) begin
                failures++;
                $display("FAIL prp_track cycle=%0d got=%b exp=%b", i, led_out, m_led);
            end
        end
        checks++;
        if (toggles != 2 || led_out !== base) begin
            failures++;
            $display("FAIL prp_count toggles=%0d exp=2 final=%b exp=%b", toggles, led_out, base);
        end
    endtask

    task automatic test_bounce();
        bit base;
        bit exp;
        settle();
        base = m_led;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, (i < 8) ? ((i % 2) == 0) : 1'b1);
            exp = base ^ (i >= 13);
            checks++;
            if (led_out !== exp) begin
                failures++;
                $display("FAIL bounce cycle=%0d got=%b exp=%b", i, led_out, exp);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        bit exp;
        settle();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        checks++;
        if (dut.cnt !== 16'd2) begin
            failures++;
            $display("FAIL midpress_cnt got=%0d exp=2", dut.cnt);
        end
        step(1'b1, 1'b1);
        checks++;
        if (led_out !== 1'b0) begin
            failures++;
            $display("FAIL midpress_reset_led got=%b exp=0", led_out);
        end
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 1'b1);
            exp = (j >= 5);
            checks++;
            if (led_out !== exp) begin
                failures++;
                $display("FAIL midpress_after edge=%0d got=%b exp=%b", j, led_out, exp);
            end
        end
    endtask

    task automatic test_random();
        bit k = 1'b0;
        int run = 0;
        bit r;
        for (int i = 0; i < 400; i++) begin
            if (run == 0) begin
                k = ~k;
                run = $urandom_range(1, 8);
            end
            run--;
            r = ($urandom_range(0, 59) == 0);
            step(r, k);
            checks++;
            if (led_out !== m_led) begin
                failures++;
                $display("FAIL random cycle=%0d got=%b exp=%b", i, led_out, m_led);
            end
        end
    endtask

    initial begin
        pipe[0] = 1'b0;
        pipe[1] = 1'b0;
        m_db  = 1'b0;
        m_led = 1'b0;
        #1;
        test_reset();
        test_clean_press();
        test_glitch();
        test_press_release_press();
        test_bounce();
        test_reset_mid_press();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
